ternary_data_memory: RTL and testbench
======================================

# ternary_data_memory

Parametrised successor to the engine's 2-bit activation/weight store: single-clock, one write port and one registered read port, plus an internal controller for auto-incrementing burst reads (feeding the MAC array one word per cycle) and a hardware clear sweep (zeroing the buffer between inference images). Sits between the layer sequencer and the datapath; depth, width and address width are generic so the same block serves layer buffers of different sizes.

## Interface
- DATA_W, 2, signed word width (ternary weights/activations by default)
- DEPTH, 256, number of entries; must be ≤ 2**ADDR_W
- ADDR_W, 9, address width of all address ports
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable
- wraddr  in  ADDR_W  write address
- wrdata  in  DATA_W  signed write data
- rd  in  1  single-word read request
- rdaddr  in  ADDR_W  read address
- burst_start  in  1  start burst read (sampled in IDLE only)
- burst_base  in  ADDR_W  first burst address
- burst_len  in  ADDR_W+1  number of words, 0..DEPTH
- clr_start  in  1  start clear sweep (sampled in IDLE only)
- rddata  out  DATA_W  signed registered read data
- rdvalid  out  1  rddata valid this cycle
- busy  out  1  burst or clear in progress
- done  out  1  one-cycle pulse at end of burst or clear

## Operation
- Storage: DEPTH x DATA_W array, no reset of contents; contents after power-up undefined until written or cleared.
- FSM states: IDLE, BURST, CLEAR.
- IDLE: clr_start -> CLEAR (ptr=0); else burst_start with burst_len≠0 -> BURST (ptr=burst_base, cnt=burst_len); burst_start with burst_len=0 -> stay IDLE, done pulse next cycle, no beats. clr_start and burst_start together: clear wins, burst dropped.
- IDLE read: rd=1 -> next cycle rdvalid=1, rddata=mem[rdaddr]; rd=0 -> rdvalid=0, rddata=0.
- BURST: each cycle read mem[ptr], ptr=(ptr+1) mod DEPTH (wrap DEPTH-1 -> 0), cnt-1; cnt reaching 0 -> IDLE. External rd ignored; writes accepted.
- CLEAR: each cycle mem[ptr]=0, ptr+1; after ptr=DEPTH-1 -> IDLE. we, rd, burst_start, clr_start ignored; rdvalid=0.
- Start requests while busy are dropped, not queued.
- Out-of-range address (≥ DEPTH): write dropped; read returns 0 with rdvalid=1. burst_base ≥ DEPTH is taken mod DEPTH.
- Read/write same address same cycle (IDLE or BURST): read returns old contents; new value visible from next cycle.
- rddata is 0 whenever rdvalid=0.

## Timing
- Reset: FSM IDLE, rddata=0, rdvalid=0, busy=0, done=0, ptr/cnt=0; memory untouched. Reset mid-burst aborts with no further beats; reset mid-clear leaves unswept entries unchanged.
- Single read: rd in cycle n -> data in cycle n+1 (latency 1).
- Write: we in cycle n -> visible to reads issued in cycle n+1.
- Burst: burst_start in cycle 0 -> busy=1 cycles 1..L; beat k (k=0..L-1) = mem[(base+k) mod DEPTH] with rdvalid=1 in cycle k+2; done=1 in cycle L+1 coincident with last beat; busy=0 from cycle L+1; new start accepted in cycle L+1.
- Clear: clr_start in cycle 0 -> busy=1 cycles 1..DEPTH; entry i zeroed at end of cycle i+1; done=1 in cycle DEPTH+1.
- done is never high for more than one cycle; never asserted for dropped requests.

## Test plan
- Write mem[5]=-1, mem[6]=+1, then rd 5, rd 6 back-to-back -> rddata -1 then +1 in consecutive cycles, rdvalid=1 each; rd=0 cycle -> rddata=0, rdvalid=0.
- Fill mem[i]=i mod 3 - 1, burst base=254, len=4 (DEPTH=256) -> beats mem[254],mem[255],mem[0],mem[1] in cycles 2..5, done in cycle 5, busy cycles 1..4.
- Same-cycle write mem[10]=+1 (old -1) and rd 10 -> rddata=-1; rd 10 next cycle -> +1.
- clr_start with burst_start and we asserted during sweep -> burst dropped, writes ignored, done at cycle 257, all 256 entries read back 0.
- burst_len=0 -> done pulse cycle 1, busy never high, rdvalid never high; wraddr=300, rdaddr=300 -> write dropped, rddata=0 with rdvalid=1.
- rst asserted in cycle 3 of a len=8 burst -> cycle 4 rdvalid=0, busy=0, done=0, no further beats; memory contents unchanged.

Source files
------------

// File: rtl/ternary_data_memory.sv
// ternary_data_memory: DEPTH x DATA_W signed buffer for ternary activations
// and weights. One write port, one registered read port, plus an internal
// controller for auto-incrementing burst reads and a full clear sweep.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   we, wraddr, wrdata       write port (dropped when wraddr >= DEPTH)
//   rd, rdaddr               single-word read, data one cycle later
//   burst_start/base/len     burst read request (IDLE only)
//   clr_start                clear sweep request (IDLE only, beats burst)
//   rddata, rdvalid          registered read data, 0 when not valid
//   busy, done               controller active / one-cycle completion pulse

module ternary_data_memory #(
   parameter int DATA_W = 2,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wraddr,
   input  logic signed [DATA_W-1:0] wrdata,
   input  logic                     rd,
   input  logic [ADDR_W-1:0]        rdaddr,
   input  logic                     burst_start,
   input  logic [ADDR_W-1:0]        burst_base,
   input  logic [ADDR_W:0]          burst_len,
   input  logic                     clr_start,
   output logic signed [DATA_W-1:0] rddata,
   output logic                     rdvalid,
   output logic                     busy,
   output logic                     done
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BURST,
      S_CLEAR
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nx;
   logic [ADDR_W-1:0]          r_ptr;
   logic [ADDR_W-1:0]          w_ptr_nx;
   logic [ADDR_W-1:0]          w_ptr_inc;
   logic [ADDR_W:0]            r_cnt;
   logic [ADDR_W:0]            w_cnt_nx;
   logic                       r_done;
   logic                       w_done_nx;

   logic                       w_rd_en;
   logic [ADDR_W-1:0]          w_rd_addr;
   logic                       w_rd_ok;
   logic                       w_wr_en;
   logic [ADDR_W-1:0]          w_wr_addr;
   logic signed [DATA_W-1:0]   w_wr_data;
   logic                       w_wr_ok;

   logic signed [DATA_W-1:0]   r_mem [DEPTH];
   logic signed [DATA_W-1:0]   r_rddata;
   logic                       r_rdvalid;

   // Pointer walks modulo DEPTH, which need not be a power of two.
   assign w_ptr_inc = (r_ptr == LP_LAST) ? '0 : r_ptr + ADDR_W'(1);

   assign w_rd_ok = ({1'b0, w_rd_addr} < LP_DEPTH);
   assign w_wr_ok = ({1'b0, w_wr_addr} < LP_DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
         r_cnt   <= w_cnt_nx;
         r_done  <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      w_cnt_nx   = r_cnt;
      w_done_nx  = 1'b0;
      w_rd_en    = 1'b0;
      w_rd_addr  = rdaddr;
      w_wr_en    = 1'b0;
      w_wr_addr  = wraddr;
      w_wr_data  = wrdata;
      case (r_state)
         S_IDLE: begin
            w_rd_en = rd;
            w_wr_en = we;
            if (clr_start) begin
               w_state_nx = S_CLEAR;
               w_ptr_nx   = '0;
            end else if (burst_start) begin
               if (burst_len != '0) begin
                  w_state_nx = S_BURST;
                  w_ptr_nx   = ADDR_W'({1'b0, burst_base} % LP_DEPTH);
                  w_cnt_nx   = burst_len;
               end else begin
                  // Empty burst: completes immediately, no beats.
                  w_done_nx = 1'b1;
               end
            end
         end
         S_BURST: begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_ptr;
            w_wr_en   = we;
            w_ptr_nx  = w_ptr_inc;
            w_cnt_nx  = r_cnt - (ADDR_W+1)'(1);
            // done lines up with the last beat leaving the read register.
            if (r_cnt == (ADDR_W+1)'(1)) begin
               w_state_nx = S_IDLE;
               w_done_nx  = 1'b1;
            end
         end
         S_CLEAR: begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_ptr;
            w_wr_data = '0;
            w_ptr_nx  = w_ptr_inc;
            if (r_ptr == LP_LAST) begin
               w_state_nx = S_IDLE;
               w_done_nx  = 1'b1;
               w_ptr_nx   = '0;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Contents are never reset; a reset cycle also blocks the write so an
   // interrupted sweep leaves remaining entries untouched.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_en && w_wr_ok) begin
         r_mem[w_wr_addr[IDX_W-1:0]] <= w_wr_data;
      end
   end

   // Read-before-write: same-cycle write is seen by the next read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdvalid <= 1'b0;
         r_rddata  <= '0;
      end else begin
         r_rdvalid <= w_rd_en;
         r_rddata  <= (w_rd_en && w_rd_ok) ? r_mem[w_rd_addr[IDX_W-1:0]] : '0;
      end
   end

   assign rddata  = r_rddata;
   assign rdvalid = r_rdvalid;
   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;

endmodule

// File: tb/tb_ternary_data_memory.sv
// Bench for ternary_data_memory: timeline-scheduling reference model checked
// every cycle, plus hand-computed literal expectations for directed vectors.

module tb_ternary_data_memory;

   localparam int DW    = 2;
   localparam int DEPTH = 256;
   localparam int AW    = 9;
   localparam int MAXC  = 4096;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 we;
   logic [AW-1:0]        wraddr;
   logic signed [DW-1:0] wrdata;
   logic                 rd;
   logic [AW-1:0]        rdaddr;
   logic                 burst_start;
   logic [AW-1:0]        burst_base;
   logic [AW:0]          burst_len;
   logic                 clr_start;
   logic signed [DW-1:0] rddata;
   logic                 rdvalid;
   logic                 busy;
   logic                 done;

   ternary_data_memory #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .we(we), .wraddr(wraddr), .wrdata(wrdata),
      .rd(rd), .rdaddr(rdaddr), .burst_start(burst_start),
      .burst_base(burst_base), .burst_len(burst_len),
      .clr_start(clr_start), .rddata(rddata), .rdvalid(rdvalid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int  mem      [DEPTH];
   int  s_raddr  [MAXC];
   int  s_clr    [MAXC];
   bit  s_busy   [MAXC];
   bit  s_done   [MAXC];
   int  busy_until = -1;
   bit  armed = 1'b0;
   int  e_valid, e_data, e_busy, e_done;

   function automatic int mread(input int a);
      return (a < DEPTH) ? mem[a] : 0;
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 0;
      for (int j = 0; j < MAXC; j++) begin
         s_raddr[j] = -1; s_clr[j] = -1; s_busy[j] = 0; s_done[j] = 0;
      end
   end

   always @(posedge clk) begin
      int c;
      bit idle;
      c = cyc;
      if (c + DEPTH + 4 >= MAXC) begin
         $display("FAIL model_horizon cycle=%0d got=%0d expected=%0d", c, c, MAXC);
         $fatal(1);
      end
      if (rst) begin
         for (int j = c + 1; j < MAXC; j++) begin
            s_raddr[j] = -1; s_clr[j] = -1; s_busy[j] = 0; s_done[j] = 0;
         end
         busy_until = c;
         e_valid = 0; e_data = 0;
         armed = 1'b1;
      end else begin
         idle = (c > busy_until);
         if (s_raddr[c+1] >= 0) begin
            e_valid = 1; e_data = mread(s_raddr[c+1]);
         end else if (idle && rd) begin
            e_valid = 1; e_data = mread(int'(rdaddr));
         end else begin
            e_valid = 0; e_data = 0;
         end
         if (s_clr[c] >= 0) mem[s_clr[c]] = 0;
         else if (we && int'(wraddr) < DEPTH) mem[wraddr] = int'(wrdata);
         if (idle && clr_start) begin
            for (int i = 0; i < DEPTH; i++) begin
               s_clr[c+1+i] = i; s_busy[c+1+i] = 1;
            end
            s_done[c+DEPTH+1] = 1;
            busy_until = c + DEPTH;
         end else if (idle && burst_start) begin
            if (burst_len == 0) s_done[c+1] = 1;
            else begin
               for (int k = 0; k < int'(burst_len); k++) begin
                  s_raddr[c+k+2] = (int'(burst_base) % DEPTH + k) % DEPTH;
                  s_busy[c+1+k] = 1;
               end
               s_done[c+int'(burst_len)+1] = 1;
               busy_until = c + int'(burst_len);
            end
         end
      end
      e_busy = s_busy[c+1];
      e_done = s_done[c+1];
      cyc = c + 1;
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("m_rdvalid", int'(rdvalid), e_valid);
         chk("m_rddata", int'(rddata), e_data);
         chk("m_busy", int'(busy), e_busy);
         chk("m_done", int'(done), e_done);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      rst = 0; we = 0; rd = 0; burst_start = 0; clr_start = 0;
   endtask

   task automatic wr(input int a, input int d);
      we = 1; wraddr = AW'(a); wrdata = DW'(d);
      tick();
   endtask

   task automatic rdq(input int a);
      rd = 1; rdaddr = AW'(a);
      tick();
   endtask

   task automatic lit(input string nm, input int v, input int d,
                      input int b, input int dn);
      @(negedge clk);
      chk({nm, "_rdvalid"}, int'(rdvalid), v);
      chk({nm, "_rddata"}, int'(rddata), d);
      chk({nm, "_busy"}, int'(busy), b);
      chk({nm, "_done"}, int'(done), dn);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d got=%0d expected=%0d", cyc, 0, 1);
      $fatal(1);
   end

   initial begin
      rst = 1; we = 0; wraddr = '0; wrdata = '0; rd = 0; rdaddr = '0;
      burst_start = 0; burst_base = '0; burst_len = '0; clr_start = 0;
      @(posedge clk); #1;
      rst = 1;
      tick();
      lit("reset", 0, 0, 0, 0);

      // back-to-back single reads
      wr(5, -1);
      wr(6, 1);
      rdq(5);
      lit("rd5", 1, -1, 0, 0);
      rdq(6);
      lit("rd6", 1, 1, 0, 0);
      tick();
      lit("rd_idle", 0, 0, 0, 0);

      // fill and wrapping burst
      for (int i = 0; i < DEPTH; i++) wr(i, (i % 3) - 1);
      burst_start = 1; burst_base = AW'(254); burst_len = 10'd4;
      tick();
      lit("bst_c1", 0, 0, 1, 0);
      tick();
      lit("bst_c2", 1, 1, 1, 0);
      tick();
      lit("bst_c3", 1, -1, 1, 0);
      tick();
      lit("bst_c4", 1, -1, 1, 0);
      tick();
      lit("bst_c5", 1, 0, 0, 1);
      tick();
      lit("bst_c6", 0, 0, 0, 0);

      // base beyond DEPTH folds back: 510 mod 256 = 254
      burst_start = 1; burst_base = AW'(510); burst_len = 10'd3;
      tick();
      repeat (5) tick();

      // read and write of the same address in one cycle
      wr(10, -1);
      we = 1; wraddr = AW'(10); wrdata = DW'(1); rd = 1; rdaddr = AW'(10);
      tick();
      lit("rw_old", 1, -1, 0, 0);
      rdq(10);
      lit("rw_new", 1, 1, 0, 0);

      // clear beats burst; writes and starts ignored during sweep
      clr_start = 1; burst_start = 1; burst_base = AW'(3); burst_len = 10'd5;
      we = 1; wraddr = AW'(7); wrdata = DW'(1);
      tick();
      for (int i = 1; i <= DEPTH; i++) begin
         we = 1; wraddr = AW'((i * 7) % DEPTH); wrdata = DW'(1);
         burst_start = 1; clr_start = (i % 2 == 0); rd = 1; rdaddr = AW'(i % DEPTH);
         tick();
      end
      lit("clr_done", 0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) begin
         rdq(i);
         @(negedge clk);
         chk("clr_zero", int'(rddata), 0);
      end
      tick();

      // empty burst and out-of-range accesses
      burst_start = 1; burst_base = AW'(0); burst_len = 10'd0;
      tick();
      lit("len0_c1", 0, 0, 0, 1);
      tick();
      lit("len0_c2", 0, 0, 0, 0);
      wr(300, 1);
      rdq(300);
      lit("oor_rd", 1, 0, 0, 0);
      rdq(44);
      lit("oor_alias", 1, 0, 0, 0);

      // reset aborts a burst in its third cycle
      for (int k = 0; k < 8; k++) wr(20 + k, ((k + 1) % 3) - 1);
      burst_start = 1; burst_base = AW'(20); burst_len = 10'd8;
      tick();
      tick();
      tick();
      rst = 1;
      tick();
      lit("rst_c4", 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clk);
         chk("rst_nobeat", int'(rdvalid), 0);
      end
      for (int k = 0; k < 8; k++) begin
         rdq(20 + k);
         @(negedge clk);
         chk("rst_keep", int'(rddata), ((k + 1) % 3) - 1);
      end
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
